mux6_rr_sequencer: RTL
======================

# mux6_rr_sequencer

Round-robin select sequencer that drives the 3-bit `ctrl` input of the `mux_6x1` data selector and registers its 8-bit `out` for a downstream valid/ready consumer. Six sources raise requests. The block arbitrates between them fairly, steers the mux to the winner, and captures the selected byte. It then acknowledges the winning source and holds the byte until the downstream stage accepts it. It sits directly upstream of `mux_6x1` for control, and directly downstream of it for data.

## Interface
Parameters:
- `WIDTH`, 8, data width; must match the `mux_6x1` data width.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  6  per-source request; bit k corresponds to mux input `in_k`.
- `mux_out`  in  WIDTH  connected to `mux_6x1.out`.
- `ctrl`  out  3  registered select to `mux_6x1.ctrl`; legal values 0..5 only.
- `gnt`  out  6  one-hot, one-cycle acknowledge to the source whose byte was captured.
- `out_data`  out  WIDTH  captured byte.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  downstream accepts `out_data` when high together with `out_valid`.

## Operation
- Reset values:
  - `ctrl`=0, `gnt`=0, `out_data`=0, `out_valid`=0.
  - Internal `last`=5, so source 0 has first priority.
  - State = IDLE.
- Arbitration:
  - Scan `req` starting at `last`+1 and wrapping 5→0; the first set bit wins.
  - All arithmetic is modulo 6; `ctrl` must never be 6 or 7.
- States:
  - IDLE:
    - `out_valid`=0 and `ctrl` holds its previous value.
    - If `req`≠0: load `ctrl` with the winner, set `last` to the winner, go to SELECT.
  - SELECT (exactly one cycle):
    - The mux is combinational, so `mux_out` reflects the new `ctrl` during this cycle.
    - At the next edge: `out_data`←`mux_out`, `out_valid`←1, `gnt`←onehot(`ctrl`), go to HOLD.
  - HOLD:
    - `gnt` returns to 0 after one cycle.
    - `out_data` and `ctrl` stay stable while `out_valid`=1 and `out_ready`=0.
    - When `out_valid`&&`out_ready`:
      - If `req`≠0: arbitrate in the same cycle, load `ctrl` and `last`, clear `out_valid`, go to SELECT.
      - Otherwise: clear `out_valid` and go to IDLE.
- Source protocol:
  - A source holds `req` and its mux input stable until it sees its `gnt` bit.
  - If `req` drops after the source has won, the block still captures and grants; this is a protocol violation, not an error state.
  - The same source may be granted again only after every other requesting source has had a turn.
- Reset mid-operation: `rst_n` low clears all state and outputs immediately, without a clock. Any captured or pending byte is discarded.

## Timing
- Latency from `req` (first seen in IDLE at edge N):
  - `ctrl` valid after edge N.
  - `out_valid`=1, `out_data` and the `gnt` pulse valid after edge N+1.
- Throughput: at most one byte per 2 cycles (SELECT + HOLD) with `out_ready` held high.
- `gnt` is high for exactly one cycle per captured byte, and in the same cycle that `out_valid` rises.
- A `req` asserted in the same cycle as an `out_ready` handshake is included in that cycle's arbitration.
- `out_valid` never depends combinationally on `out_ready`; all outputs are registered.

## Test plan
Bench instantiates the real `mux_6x1` with `in_k`=k (matching the existing mux bench pattern) and `WIDTH`=8.

- Reset: hold `rst_n`=0 with `req`=6'h3F → `ctrl`=0, `gnt`=0, `out_valid`=0, `out_data`=0.
- Single request:
  - Stimulus: `req`=6'b001000, `out_ready`=1.
  - Response: `ctrl`=3 after the first edge; after the second edge `out_valid`=1, `out_data`=8'h03, `gnt`=6'b001000 for one cycle.
- Full contention:
  - Stimulus: `req`=6'h3F, `out_ready`=1, run 14 cycles.
  - Response: `out_data` sequence 0,1,2,3,4,5,0; one `gnt` every 2 cycles; `ctrl` never >5.
- Backpressure:
  - Stimulus: `req`=6'h3F, `out_ready`=0 for 6 cycles after the first capture.
  - Response: `out_data`=0, `out_valid`=1, `ctrl`=0 all held; no further `gnt`. Raising `out_ready` produces the next capture, 8'h01, two cycles later.
- Wrap-around:
  - Stimulus: after source 5 is granted, `req`=6'b100001.
  - Response: source 0 is granted next (`out_data`=8'h00), then source 5.
- Asynchronous reset in HOLD:
  - Stimulus: drop `rst_n` mid-cycle while `out_valid`=1.
  - Response: all outputs are 0 before the next clock edge. After release with `req`=6'b000100, the first grant goes to source 2.

Source files
------------

// File: rtl/mux6_rr_sequencer.sv
// mux6_rr_sequencer
// -----------------
// Round-robin select sequencer for a 6:1 data selector (mux_6x1).
// Six sources raise requests; the block picks a winner fairly, steers the
// mux select to it, captures the selected byte one cycle later, pulses a
// one-hot grant back to the winner and holds the byte under valid/ready
// until the downstream stage takes it.
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   req        in   6      per-source request, bit k <-> mux input in_k
//   mux_out    in   WIDTH  data returned by mux_6x1.out
//   ctrl       out  3      registered mux select, only ever 0..5
//   gnt        out  6      one-hot, one-cycle acknowledge of the captured source
//   out_data   out  WIDTH  captured byte
//   out_valid  out  1      out_data is valid
//   out_ready  in   1      downstream accepts out_data when out_valid is high
module mux6_rr_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       req,
  input  logic [WIDTH-1:0] mux_out,
  output logic [2:0]       ctrl,
  output logic [5:0]       gnt,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  // Source 5 counts as the most recent winner after reset so source 0 goes first.
  localparam logic [2:0] LAST_RESET = 3'd5;

  // Round-robin pick: scan from last+1 upward, wrapping 5 -> 0. The wrap
  // test uses >= so that even a corrupted last value can never index past 5.
  function automatic logic [2:0] rr_pick(input logic [5:0] r, input logic [2:0] last);
    logic [2:0] idx;
    logic [2:0] pick;
    logic       found;
    idx   = last;
    pick  = 3'd0;
    found = 1'b0;
    for (int i = 0; i < 6; i++) begin
      idx = (idx >= 3'd5) ? 3'd0 : (idx + 3'd1);
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end else begin
        pick  = pick;
      end
    end
    return pick;
  endfunction

  // One-hot grant vector for a select value; out-of-range selects give no grant.
  function automatic logic [5:0] onehot6(input logic [2:0] sel);
    logic [5:0] v;
    case (sel)
      3'd0:    v = 6'b000001;
      3'd1:    v = 6'b000010;
      3'd2:    v = 6'b000100;
      3'd3:    v = 6'b001000;
      3'd4:    v = 6'b010000;
      3'd5:    v = 6'b100000;
      default: v = 6'b000000;
    endcase
    return v;
  endfunction

  state_t           state_q, state_d;
  logic [2:0]       ctrl_q, ctrl_d;
  logic [2:0]       last_q, last_d;
  logic [5:0]       gnt_q, gnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic [2:0]       pick_s;
  logic             any_req_s;

  assign pick_s    = rr_pick(req, last_q);
  assign any_req_s = (req != 6'b000000);

  // Next-state and next-output logic for the IDLE/SELECT/HOLD sequence.
  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    last_d  = last_q;
    gnt_d   = 6'b000000;  // grant is a single-cycle pulse
    data_d  = data_q;
    valid_d = valid_q;
    case (state_q)
      ST_IDLE: begin
        valid_d = 1'b0;
        if (any_req_s) begin
          ctrl_d  = pick_s;
          last_d  = pick_s;
          state_d = ST_SELECT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SELECT: begin
        // mux_out already reflects ctrl_q through the combinational mux.
        data_d  = mux_out;
        valid_d = 1'b1;
        gnt_d   = onehot6(ctrl_q);
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (valid_q && out_ready) begin
          valid_d = 1'b0;
          if (any_req_s) begin
            // Requests present at the handshake join this arbitration.
            ctrl_d  = pick_s;
            last_d  = pick_s;
            state_d = ST_SELECT;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ctrl_q  <= 3'd0;
      last_q  <= LAST_RESET;
      gnt_q   <= 6'b000000;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign ctrl      = ctrl_q;
  assign gnt       = gnt_q;
  assign out_data  = data_q;
  assign out_valid = valid_q;

endmodule
